rib_rom_loader: RTL
===================

// Module: rib_rom_loader
// PURPOSE
//  RIB bus initiator that loads a program image into the instruction ROM (or any RIB
//  write slave) from a byte stream, e.g. the UART debug receiver. Parses a framed
//  packet, assembles little-endian words, issues one RIB write per word and verifies
//  an XOR checksum. Asserts halt_o while loading so the core stays off the bus.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address of word 0; must be word aligned
//  MAX_WORDS    4096           largest accepted length; must equal ROM depth (RomNum)
//  ACK_TIMEOUT  16             max cycles req_o may wait for ack_i before abort
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous reset, active-high
//  start_i     in   1   pulse: begin new packet (ignored while busy_o=1)
//  rx_valid_i  in   1   byte valid
//  rx_data_i   in   8   byte data
//  rx_ready_o  out  1   byte accepted when rx_valid_i & rx_ready_o at clk edge
//  req_o       out  1   RIB request
//  we_o        out  1   RIB write enable
//  addr_o      out  32  RIB byte address
//  data_o      out  32  RIB write data
//  ack_i       in   1   RIB acknowledge from slave
//  halt_o      out  1   hold CPU off the bus; equals busy_o
//  busy_o      out  1   packet in progress
//  done_o      out  1   one-cycle pulse: packet loaded, checksum good
//  err_o       out  1   sticky error flag; cleared by accepted start_i
//  err_code_o  out  2   0 none, 1 length>MAX_WORDS, 2 checksum mismatch, 3 ack timeout
//  words_o     out  16  words written in current/last packet
// BEHAVIOUR
//  Reset: state IDLE; every output 0; internal count, checksum and timer 0.
//  Packet: LEN_LO, LEN_HI (N words, 16 bit LE), 4*N data bytes (LE per word),
//   CSUM byte = XOR of all 4*N data bytes (length bytes excluded).
//  States and transitions:
//   IDLE: rx_ready_o=0. start_i -> LEN0; clears err_o, err_code_o, words_o, csum.
//   LEN0: rx_ready_o=1; byte -> len[7:0]; -> LEN1.
//   LEN1: rx_ready_o=1; byte -> len[15:8]. len>MAX_WORDS -> ERR, code 1.
//         len==0 -> CSUM. Else -> DATA, byte index 0.
//   DATA: rx_ready_o=1; byte k goes to word[8k+7:8k]; csum ^= byte. After byte 3
//         -> WRITE; data_o=word, addr_o=BASE_ADDR+4*words_o.
//   WRITE: rx_ready_o=0; req_o=we_o=1; addr_o/data_o stable while req_o=1.
//         Write completes at the first clk edge where ack_i=1. That edge drops
//         req_o/we_o, increments words_o, and goes to CSUM if words_o+1==len,
//         else DATA. Timer counts cycles with ack_i=0; at ACK_TIMEOUT -> ERR,
//         code 3, with req_o/we_o deasserted.
//   CSUM: rx_ready_o=1; byte==csum -> IDLE with done_o pulse for one cycle;
//         mismatch -> ERR, code 2.
//   ERR: err_o=1 (sticky), busy_o=0, rx_ready_o=1: drains and drops bytes so the
//        UART never stalls. start_i -> LEN0 with err cleared.
//  busy_o=1 in LEN0, LEN1, DATA, WRITE and CSUM; 0 in IDLE and ERR.
//  Latency: with ack_i tied high, each WRITE lasts exactly 1 cycle, so the loader
//   takes one extra cycle per 4 bytes. done_o is asserted in the cycle after the
//   CSUM byte is accepted.
//  req_o is never asserted outside WRITE; we_o==req_o always; no read requests.
//  Address arithmetic is 32-bit: BASE_ADDR + (words_o<<2). It cannot wrap because
//   len<=MAX_WORDS.
//  rx_valid_i while rx_ready_o=0: the byte is not consumed; the source holds it.
//  start_i is ignored while busy_o=1; no restart happens mid-packet.
//  Reset mid-operation (including mid-WRITE): req_o/we_o are 0 the cycle after the
//   reset edge; the partial word is discarded; already-written words are not undone.
// TESTING
//  1. ack_i=1, start, bytes 02 00 | 11 22 33 44 | 55 66 77 88 | 88 -> writes
//     0x44332211 @BASE, 0x88776655 @BASE+4; done_o pulse; words_o=2; err_o=0.
//  2. Same packet with the checksum byte 0x00 -> both writes occur; err_o=1;
//     err_code_o=2; no done_o; later bytes are drained with rx_ready_o=1.
//  3. Length bytes 01 10 (0x1001 > 4096) -> ERR, err_code_o=1, req_o never asserted.
//  4. ack_i held low for 3 cycles in the first WRITE -> req_o/addr_o/data_o stable
//     for 4 cycles, then one write. ack_i low for 16 cycles -> err_code_o=3, req_o=0.
//  5. Length 00 00, checksum 00 -> done_o pulse with zero writes. start_i while
//     busy -> ignored. rst in WRITE -> req_o=0 next cycle, all outputs 0, IDLE.

Source files
------------

// File: rtl/rib_rom_loader.sv
// RIB write initiator that loads a program image from a byte stream.
// Packet: LEN_LO, LEN_HI, 4*N little-endian data bytes, XOR checksum byte.
// One RIB write per assembled word; halt_o keeps the core off the bus while loading.
module rib_rom_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic        ack_i,
  output logic        halt_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] words_o
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLen0  = 3'd1;
  localparam logic [2:0] StLen1  = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StCsum  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [23:0]       word_q, word_d;     // bytes 0..2 of the word being assembled
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [15:0]       words_q, words_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              done_q, done_d;
  logic              accept;
  logic [15:0]       len_full;

  // Byte handshake is open in every state that consumes bytes, including ERR (drain).
  always_comb begin
    rx_ready_o = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      StLen0, StLen1, StData, StCsum: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      StWrite: busy_o = 1'b1;
      StErr:   rx_ready_o = 1'b1;
      default: ;
    endcase
  end

  assign accept     = rx_valid_i & rx_ready_o;
  assign len_full   = {rx_data_i, len_q[7:0]};
  assign req_o      = (state_q == StWrite);
  assign we_o       = req_o;
  assign halt_o     = busy_o;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign words_o    = words_q;

  // Packet parser / write sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    timer_d    = timer_q;
    words_d    = words_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle, StErr: begin
        if (start_i) begin
          state_d    = StLen0;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          words_d    = 16'd0;
          csum_d     = 8'd0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_d[7:0] = rx_data_i;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d[15:8] = rx_data_i;
          if (32'(len_full) > MAX_WORDS) begin
            state_d    = StErr;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
            idx_d   = 2'd0;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data_i;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
            data_d  = {rx_data_i, word_q};
            timer_d = '0;
            state_d = StWrite;
          end else begin
            word_d[idx_q*8 +: 8] = rx_data_i;
          end
        end
      end
      StWrite: begin
        if (ack_i) begin
          words_d = words_q + 16'd1;
          idx_d   = 2'd0;
          state_d = (words_q + 16'd1 == len_q) ? StCsum : StData;
        end else if (timer_q == TimerW'(ACK_TIMEOUT - 1)) begin
          state_d    = StErr;
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCsum: begin
        if (accept) begin
          if (rx_data_i == csum_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d    = StErr;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset returns everything to zero / IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      timer_q    <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      timer_q    <= timer_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
    end
  end

endmodule
